// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg: shared op/state encodings for the JK bank controller
package jk_bank_pkg;
    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_CLEAR = 2'b01,
        OP_COUNT = 2'b10,
        OP_SHIFT = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_LEN_W = 8;
endpackage

// File: rtl/jk_bank_if.sv
// jk_bank_if: command valid/ready bus into the JK bank controller
//   cmd_valid/cmd_op/cmd_data/cmd_len : host -> controller
//   cmd_ready                         : controller -> host
interface jk_bank_if #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;
    modport master (output cmd_valid, cmd_op, cmd_data, cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop (00 hold, 01 reset, 10 set, 11 toggle)
//   clk, rst (sync active-high) ; j_i, k_i : JK inputs ; q_o : flop state
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);
    logic q_q;
    always_ff @(posedge clk)
        if (rst) q_q <= 1'b0;
        else     q_q <= j_i && k_i ? ~q_q : j_i ? 1'b1 : k_i ? 1'b0 : q_q;
    assign q_o = q_q;
endmodule

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command sequencer driving J/K of a WIDTH-bit JK flop bank
//   clk, rst      : clock, sync active-high reset
//   cmd (slave)   : valid/ready command bus (op, data, len)
//   pause         : freezes RUN, present only when JK_PAUSE_EN is defined
//   busy, done, q : RUN flag, one-cycle completion pulse, bank state
module jk_bank_ctrl
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    jk_bank_if.slave         cmd,
`ifdef JK_PAUSE_EN
    input  logic             pause,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q
);
    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] data_q, j, k, tog, sh;
    logic [LEN_W-1:0] cnt_q, len_d;
    logic             ready_q, busy_q, done_q, adv;
`ifdef JK_PAUSE_EN
    assign adv = state_q == ST_RUN && !pause;
`else
    assign adv = state_q == ST_RUN;
`endif
    // LOAD/CLEAR (op[1]=0) are always a single step
    assign len_d = cmd.cmd_op[1] ? cmd.cmd_len : LEN_W'(1);
    assign tog[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_tog
        assign tog[i] = &q[i-1:0];
    end
    assign sh = {q[WIDTH-2:0], data_q[0]};
    assign j = !adv ? '0 : op_q == OP_LOAD ? data_q  : op_q == OP_CLEAR ? '0 : op_q == OP_COUNT ? tog : sh;
    assign k = !adv ? '0 : op_q == OP_LOAD ? ~data_q : op_q == OP_CLEAR ? '1 : op_q == OP_COUNT ? tog : ~sh;
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (.clk(clk), .rst(rst), .j_i(j[i]), .k_i(k[i]), .q_o(q[i]));
    end
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (ready_q && cmd.cmd_valid) begin
                        op_q    <= op_e'(cmd.cmd_op);
                        data_q  <= cmd.cmd_data;
                        cnt_q   <= len_d;
                        ready_q <= 1'b0;
                        // zero-length commands skip RUN and never raise busy
                        state_q <= len_d == '0 ? ST_DONE : ST_RUN;
                        busy_q  <= len_d != '0;
                        done_q  <= len_d == '0;
                    end
                end
                ST_RUN:
                    if (adv) begin
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    assign cmd.cmd_ready = ready_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb_jk_bank_ctrl: scoreboard bench with an integer reference model of the JK bank
module tb_jk_bank_ctrl;
    localparam int W  = 4;
    localparam int LW = 8;
    localparam int M  = (1 << W) - 1;
    typedef struct {int exp_q; int lat;} exp_t;
    logic clk = 1'b0, rst = 1'b1, pause = 1'b0;
    logic busy, done;
    logic [W-1:0] q;
    exp_t sb[$];
    int steps_q[$];
    int n_tests = 0, n_fail = 0, m_q = 0, acc_cnt = -1;
    logic prev_step = 1'b0, prev_hold = 1'b0;
    logic [W-1:0] last_q = '0;
    always #5 clk = ~clk;
    jk_bank_if #(.WIDTH(W), .LEN_W(LW)) cmd ();
    jk_bank_ctrl #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk(clk),
        .rst(rst),
        .cmd(cmd),
`ifdef JK_PAUSE_EN
        .pause(pause),
`endif
        .busy(busy),
        .done(done),
        .q(q)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int model_step(input int op, input int d, input int v);
        case (op)
            0:       return d & M;
            1:       return 0;
            2:       return (v + 1) & M;
            default: return ((v << 1) | (d & 1)) & M;
        endcase
    endfunction
    task automatic issue(input int op, input int data, input int len, input int extra, output int waited);
        int steps;
        logic ok;
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = 2'(op);
        cmd.cmd_data  = W'(data);
        cmd.cmd_len   = LW'(len);
        waited = 0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            waited++;
            ok = cmd.cmd_ready;
        end
        if (!ok) begin
            check("accept timeout", 0, 1);
            cmd.cmd_valid = 1'b0;
            return;
        end
        steps = op < 2 ? 1 : len;
        for (int s = 0; s < steps; s++) begin
            m_q = model_step(op, data, m_q);
            steps_q.push_back(m_q);
        end
        sb.push_back('{m_q, steps + 1 + extra});
        @(posedge clk);
        #1;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'($urandom);
        cmd.cmd_data  = W'($urandom);
        cmd.cmd_len   = LW'($urandom);
    endtask
    always @(negedge clk) begin
        exp_t e;
        int sv;
        if (rst) begin
            prev_step = 1'b0;
            prev_hold = 1'b0;
            acc_cnt   = -1;
        end else begin
            if (acc_cnt >= 0) acc_cnt++;
            if (prev_step) begin
                if (steps_q.size() == 0) check("step underflow", 1, 0);
                else begin
                    sv = steps_q.pop_front();
                    check("step q", q, sv);
                end
            end
            if (prev_hold) check("pause hold q", q, last_q);
            if (done) begin
                if (sb.size() == 0) check("unexpected done", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("done q", q, e.exp_q);
                    check("done latency", acc_cnt, e.lat);
                    check("busy at done", busy, 0);
                end
            end
            if (cmd.cmd_valid && cmd.cmd_ready) acc_cnt = 0;
            prev_step = busy && !pause;
            prev_hold = busy && pause;
            last_q    = q;
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int w;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = '0;
        cmd.cmd_data  = '0;
        cmd.cmd_len   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset q", q, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset ready", cmd.cmd_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready after reset", cmd.cmd_ready, 1);
        @(posedge clk); #1;
        // mid-command reset aborts COUNT without a done pulse
        issue(0, 0, 0, 0, w);
        issue(2, 0, 10, 0, w);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        steps_q.delete();
        m_q = 0;
        @(posedge clk);
        @(negedge clk);
        check("abort q", q, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort ready", cmd.cmd_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready after abort", cmd.cmd_ready, 1);
        @(posedge clk); #1;
        issue(0, 4'b1010, 7, 0, w);
        issue(1, 4'b1111, 9, 0, w);
        issue(0, 4'b1110, 0, 0, w);
        issue(2, 0, 3, 0, w);
        issue(0, 4'b0000, 0, 0, w);
        issue(3, 4'b0001, 4, 0, w);
        issue(2, $urandom, 0, 0, w);
        issue(0, 4'b0101, 0, 0, w);
        check("back-to-back accept wait", w, 2);
        issue(3, 4'b1110, 3, 0, w);
        issue(2, 0, 20, 0, w);
`ifdef JK_PAUSE_EN
        issue(0, 0, 0, 0, w);
        issue(2, 0, 4, 2, w);
        @(posedge clk); #1 pause = 1'b1;
        repeat (2) @(posedge clk);
        #1 pause = 1'b0;
        issue(2, 0, 1, 0, w);
`endif
        for (int n = 0; n < 40; n++) begin
            issue($urandom_range(0, 3), $urandom, $urandom_range(0, 5), 0, w);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        check("steps drained", steps_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
